// File: rtl/instruction_loader.sv
// Instruction-memory loader: takes a length-prefixed little-endian byte stream,
// writes 32-bit words to instruction memory and holds the core in reset until done.
module instruction_loader #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned MAX_WORDS  = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startLoad,
  input  logic [7:0]  byteIn,
  input  logic        byteValid,
  output logic        byteReady,
  output logic        memWrite,
  output logic [31:0] memAddress,
  output logic [31:0] memWriteData,
  output logic        coreReset,
  output logic        loadDone,
  output logic        loadError
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    DONE   = 3'd4,
    ERROR  = 3'd5
  } state_t;

  state_t                  state_q, state_d;
  logic [15:0]             count_q, count_d;
  logic [1:0]              byte_idx_q, byte_idx_d;
  logic [ADDR_WIDTH-1:0]   word_idx_q, word_idx_d;
  logic [23:0]             asm_q, asm_d;
  logic                    byte_ready_q, byte_ready_d;
  logic                    mem_write_q, mem_write_d;
  logic [31:0]             mem_addr_q, mem_addr_d;
  logic [31:0]             mem_data_q, mem_data_d;
  logic                    core_reset_q, core_reset_d;
  logic                    load_done_q, load_done_d;
  logic                    load_error_q, load_error_d;

  logic        fire;
  logic [15:0] hdr_count;
  logic        last_word;

  assign fire      = byteValid && byte_ready_q;
  assign hdr_count = {byteIn, count_q[7:0]};
  assign last_word = (32'(word_idx_q) == (32'(count_q) - 32'd1));

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    byte_idx_d = byte_idx_q;
    word_idx_d = word_idx_q;
    asm_d      = asm_q;
    mem_write_d = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;

    case (state_q)
      IDLE, DONE, ERROR: begin
        if (startLoad) begin
          state_d    = LEN_LO;
          count_d    = '0;
          byte_idx_d = '0;
          word_idx_d = '0;
          asm_d      = '0;
        end
      end
      LEN_LO: begin
        if (fire) begin
          count_d[7:0] = byteIn;
          state_d      = LEN_HI;
        end
      end
      LEN_HI: begin
        if (fire) begin
          count_d[15:8] = byteIn;
          byte_idx_d    = '0;
          word_idx_d    = '0;
          if (hdr_count == 16'd0 || 32'(hdr_count) > MAX_WORDS) state_d = ERROR;
          else                                                   state_d = DATA;
        end
      end
      DATA: begin
        if (fire) begin
          byte_idx_d = byte_idx_q + 2'd1;
          case (byte_idx_q)
            2'd0: asm_d[7:0]   = byteIn;
            2'd1: asm_d[15:8]  = byteIn;
            2'd2: asm_d[23:16] = byteIn;
            default: begin
              // Lane 3 goes straight into the write data, so the word is issued on this edge.
              mem_data_d  = {byteIn, asm_q};
              mem_addr_d  = 32'(word_idx_q) << 2;
              mem_write_d = 1'b1;
              word_idx_d  = word_idx_q + 1'b1;
              if (last_word) state_d = DONE;
            end
          endcase
        end
      end
      default: state_d = IDLE;
    endcase

    byte_ready_d = (state_d == LEN_LO) || (state_d == LEN_HI) || (state_d == DATA);
    // Release is delayed to the first edge spent in DONE, one cycle after the final write.
    load_done_d  = (state_q == DONE) && (state_d == DONE);
    core_reset_d = !load_done_d;
    load_error_d = (state_d == ERROR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      count_q      <= '0;
      byte_idx_q   <= '0;
      word_idx_q   <= '0;
      asm_q        <= '0;
      byte_ready_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      core_reset_q <= 1'b1;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      byte_idx_q   <= byte_idx_d;
      word_idx_q   <= word_idx_d;
      asm_q        <= asm_d;
      byte_ready_q <= byte_ready_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      core_reset_q <= core_reset_d;
      load_done_q  <= load_done_d;
      load_error_q <= load_error_d;
    end
  end

  assign byteReady    = byte_ready_q;
  assign memWrite     = mem_write_q;
  assign memAddress   = mem_addr_q;
  assign memWriteData = mem_data_q;
  assign coreReset    = core_reset_q;
  assign loadDone     = load_done_q;
  assign loadError    = load_error_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Scoreboard bench for instruction_loader: a byte-list model predicts memory writes,
// a negedge monitor checks every write strobe against the expected queue.
module tb_instruction_loader;

  localparam int AW = 8;
  localparam int MW = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic        startLoad;
  logic [7:0]  byteIn;
  logic        byteValid;
  logic        byteReady;
  logic        memWrite;
  logic [31:0] memAddress;
  logic [31:0] memWriteData;
  logic        coreReset;
  logic        loadDone;
  logic        loadError;

  instruction_loader #(.ADDR_WIDTH(AW), .MAX_WORDS(MW)) dut (
    .clk(clk), .reset(reset), .startLoad(startLoad), .byteIn(byteIn),
    .byteValid(byteValid), .byteReady(byteReady), .memWrite(memWrite),
    .memAddress(memAddress), .memWriteData(memWriteData), .coreReset(coreReset),
    .loadDone(loadDone), .loadError(loadError)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  int stalls = 0;
  logic [63:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected (addr, data).
  always @(negedge clk) begin
    if (memWrite === 1'b1) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h expected no write",
                 memAddress, memWriteData);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("write_addr", memAddress, e[63:32]);
        chk("write_data", memWriteData, e[31:0]);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap, input bit pulse);
    bit got;
    for (int g = 0; g < gap; g++) begin
      byteValid = 1'b0;
      byteIn = 8'($urandom);
      @(posedge clk); #1;
    end
    byteValid = 1'b1;
    byteIn = b;
    startLoad = pulse;
    got = 1'b0;
    for (int t = 0; t < 100 && !got; t++) begin
      @(negedge clk);
      if (byteReady) begin
        @(posedge clk); #1;
        got = 1'b1;
      end else stalls++;
    end
    byteValid = 1'b0;
    startLoad = 1'b0;
    byteIn = 8'($urandom);
    if (!got) begin
      compared++;
      mismatched++;
      $display("FAIL send_timeout: got no byteReady expected byteReady within 100 cycles");
    end
  endtask

  task automatic start_load();
    startLoad = 1'b1;
    @(posedge clk); #1;
    startLoad = 1'b0;
    chk("start_byteReady", 32'(byteReady), 32'd1);
    chk("start_loadDone", 32'(loadDone), 32'd0);
    chk("start_loadError", 32'(loadError), 32'd0);
    chk("start_coreReset", 32'(coreReset), 32'd1);
  endtask

  function automatic int pick_gap(input int maxgap);
    return (maxgap == 0) ? 0 : int'($urandom_range(0, maxgap));
  endfunction

  // Reference: word i is bytes 4i..4i+3 little-endian, written at byte address 4*i.
  task automatic run_load(input logic [15:0] hdr, input int maxgap,
                          input logic [7:0] data[$], input int pulse_at);
    bit legal;
    start_load();
    stalls = 0;
    legal = (hdr != 16'd0) && (int'(hdr) <= MW);
    if (legal)
      for (int i = 0; i < int'(hdr); i++)
        exp_q.push_back({32'(i * 4), data[4*i+3], data[4*i+2], data[4*i+1], data[4*i]});
    send_byte(hdr[7:0], pick_gap(maxgap), 1'b0);
    send_byte(hdr[15:8], pick_gap(maxgap), 1'b0);
    if (!legal) begin
      chk("err_loadError", 32'(loadError), 32'd1);
      chk("err_coreReset", 32'(coreReset), 32'd1);
      chk("err_byteReady", 32'(byteReady), 32'd0);
      chk("err_loadDone", 32'(loadDone), 32'd0);
      byteValid = 1'b1;
      for (int k = 0; k < 3; k++) begin
        byteIn = 8'($urandom);
        @(posedge clk); #1;
        chk("err_no_accept", 32'(byteReady), 32'd0);
      end
      byteValid = 1'b0;
      chk("err_still_error", 32'(loadError), 32'd1);
      return;
    end
    for (int j = 0; j < 4 * int'(hdr); j++)
      send_byte(data[j], pick_gap(maxgap), j == pulse_at);
    chk("last_edge_coreReset", 32'(coreReset), 32'd1);
    chk("last_edge_loadDone", 32'(loadDone), 32'd0);
    @(posedge clk); #1;
    chk("done_coreReset", 32'(coreReset), 32'd0);
    chk("done_loadDone", 32'(loadDone), 32'd1);
    chk("done_byteReady", 32'(byteReady), 32'd0);
    chk("done_loadError", 32'(loadError), 32'd0);
    chk("writes_outstanding", 32'(exp_q.size()), 32'd0);
    if (maxgap == 0) chk("full_rate_stalls", 32'(stalls), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_byteReady"}, 32'(byteReady), 32'd0);
    chk({tag, "_memWrite"}, 32'(memWrite), 32'd0);
    chk({tag, "_memAddress"}, memAddress, 32'd0);
    chk({tag, "_memWriteData"}, memWriteData, 32'd0);
    chk({tag, "_coreReset"}, 32'(coreReset), 32'd1);
    chk({tag, "_loadDone"}, 32'(loadDone), 32'd0);
    chk({tag, "_loadError"}, 32'(loadError), 32'd0);
  endtask

  initial begin
    logic [7:0] d[$];
    logic [7:0] prog[$];
    reset = 1'b1;
    startLoad = 1'b0;
    byteIn = 8'h00;
    byteValid = 1'b0;
    #3;
    check_reset_values("reset");
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    // Stream in IDLE without startLoad: nothing may be accepted
    byteValid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      byteIn = 8'($urandom);
      @(posedge clk); #1;
      chk("idle_no_accept", 32'(byteReady), 32'd0);
    end
    byteValid = 1'b0;

    prog = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00};
    run_load(16'd2, 0, prog, -1);
    run_load(16'd2, 3, prog, -1);

    d = {};
    run_load(16'd0, 2, d, -1);
    run_load(16'(MW + 1), 2, d, -1);

    d = {};
    for (int i = 0; i < 255; i++) begin
      d.push_back(8'(i)); d.push_back(8'h00); d.push_back(8'h00); d.push_back(8'h00);
    end
    run_load(16'd255, 0, d, -1);
    d = {};
    for (int i = 0; i < 4 * MW; i++) d.push_back(8'($urandom));
    run_load(16'(MW), 0, d, -1);

    // Asynchronous abort after 6 data bytes of a 2-word load
    d = {};
    for (int i = 0; i < 8; i++) d.push_back(8'($urandom));
    start_load();
    exp_q.push_back({32'd0, d[3], d[2], d[1], d[0]});
    send_byte(8'h02, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    for (int j = 0; j < 6; j++) send_byte(d[j], 0, 1'b0);
    #2 reset = 1'b1;
    #1 check_reset_values("abort");
    chk("abort_outstanding", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    prog = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_load(16'd1, 0, prog, -1);

    // startLoad mid-DATA is ignored; startLoad from ERROR restarts cleanly
    d = {};
    for (int i = 0; i < 12; i++) d.push_back(8'($urandom));
    run_load(16'd3, 0, d, 5);
    run_load(16'd0, 0, d, -1);
    run_load(16'd3, 2, d, -1);

    for (int r = 0; r < 4; r++) begin
      int n;
      n = int'($urandom_range(1, 6));
      d = {};
      for (int i = 0; i < 4 * n; i++) d.push_back(8'($urandom));
      run_load(16'(n), 3, d, int'($urandom_range(0, 4 * n - 2)));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("final_outstanding", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish before 2ms");
    $fatal(1, "timeout");
  end

endmodule
